// File: rtl/i2c_dac_writer.sv
// Single-shot I2C master that writes one 12-bit code plus power-down bits to a DAC.
// Define I2C_DAC_WRITER_NACK_ABORT_EN to end the frame with STOP right after a NACKed ACK slot.
module i2c_dac_writer #(
  parameter int unsigned CLK_DIV  = 63,
  parameter logic [6:0]  DEV_ADDR = 7'h60,
  parameter int unsigned DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        pd_i,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              nack
);

  localparam int unsigned QW        = 10;
  localparam int unsigned BW        = 5;
  localparam int unsigned CW        = 12;
  localparam int unsigned LSH       = CW - DATA_W;
  localparam int unsigned LAST_SLOT = 26;

`ifdef I2C_DAC_WRITER_NACK_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [QW-1:0]   r_qcnt, w_qcnt_nxt;
  logic [1:0]      r_quarter, w_quarter_nxt;
  logic [BW-1:0]   r_bit, w_bit_nxt;
  logic [CW-1:0]   r_code, w_code_nxt;
  logic [1:0]      r_pd, w_pd_nxt;
  logic            r_scl_oe, w_scl_oe_nxt;
  logic            r_sda_oe, w_sda_oe_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_nack, w_nack_nxt;

  logic            w_tick;
  logic            w_is_ack;
  logic            w_bit_val;
  logic [0:26]     w_frame;
  logic [CW-1:0]   w_code_in;

  assign w_code_in = CW'(data_i) << LSH;
  assign w_tick    = (r_qcnt == QW'(CLK_DIV - 1));
  assign w_is_ack  = (r_bit == BW'(8)) || (r_bit == BW'(17)) || (r_bit == BW'(LAST_SLOT));
  // Slot-ordered frame; ACK positions hold 1 so SDA is released there
  assign w_frame   = {DEV_ADDR, 1'b0, 1'b1, 2'b00, r_pd, r_code[11:8], 1'b1, r_code[7:0], 1'b1};
  assign w_bit_val = w_frame[r_bit];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_qcnt_nxt    = '0;
    w_quarter_nxt = r_quarter;
    w_bit_nxt     = r_bit;
    w_code_nxt    = r_code;
    w_pd_nxt      = r_pd;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_nack_nxt    = r_nack;
    w_scl_oe_nxt  = 1'b0;
    w_sda_oe_nxt  = 1'b0;

    if (r_state inside {S_START, S_BITS, S_STOP})
      w_qcnt_nxt = w_tick ? '0 : r_qcnt + QW'(1);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_START;
          w_quarter_nxt = 2'd0;
          w_bit_nxt     = '0;
          w_code_nxt    = w_code_in;
          w_pd_nxt      = pd_i;
          w_busy_nxt    = 1'b1;
          w_nack_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_quarter == 2'd1) begin
            w_state_nxt   = S_BITS;
            w_quarter_nxt = 2'd0;
            w_bit_nxt     = '0;
          end else begin
            w_quarter_nxt = r_quarter + 2'd1;
          end
        end
      end
      S_BITS: begin
        if (w_tick && (r_quarter == 2'd1) && w_is_ack)
          w_nack_nxt = r_nack | sda_i;
        if (w_tick) begin
          if (r_quarter == 2'd3) begin
            w_quarter_nxt = 2'd0;
            if ((r_bit == BW'(LAST_SLOT)) || (ABORT_EN && w_is_ack && r_nack))
              w_state_nxt = S_STOP;
            else
              w_bit_nxt = r_bit + BW'(1);
          end else begin
            w_quarter_nxt = r_quarter + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_quarter == 2'd2) begin
            w_state_nxt   = S_DONE;
            w_quarter_nxt = 2'd0;
            w_bit_nxt     = '0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
          end else begin
            w_quarter_nxt = r_quarter + 2'd1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line drive trails the position by one clk; SDA moves one clk after SCL falls
    case (r_state)
      S_START: begin
        w_sda_oe_nxt = (r_quarter == 2'd1);
      end
      S_BITS: begin
        w_scl_oe_nxt = (r_quarter == 2'd0) || (r_quarter == 2'd3);
        w_sda_oe_nxt = ((r_quarter == 2'd0) && (r_qcnt != '0)) ? ~w_bit_val : r_sda_oe;
      end
      S_STOP: begin
        w_scl_oe_nxt = (r_quarter == 2'd0);
        w_sda_oe_nxt = (r_quarter != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qcnt    <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
      r_code    <= '0;
      r_pd      <= '0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_qcnt    <= w_qcnt_nxt;
      r_quarter <= w_quarter_nxt;
      r_bit     <= w_bit_nxt;
      r_code    <= w_code_nxt;
      r_pd      <= w_pd_nxt;
      r_scl_oe  <= w_scl_oe_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_nack    <= w_nack_nxt;
    end
  end

  assign scl_oe = r_scl_oe;
  assign sda_oe = r_sda_oe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign nack   = r_nack;

endmodule

// File: doc/i2c_dac_writer.md
I2C_DAC_WRITER -- requirements
Module: i2c_dac_writer

Interface
REQ-001 Parameter CLK_DIV, default 63: clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk); legal range 2..1023.
REQ-002 Parameter DEV_ADDR, default 7'h60: 7-bit I2C slave address sent in the first byte.
REQ-003 Parameter DATA_W, default 12: DAC code width; legal values 8, 10, 12; the code is left-aligned into the 12-bit field and LSBs are zero-filled.
REQ-004 clk  input  1: single system clock; all logic is on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 start  input  1: one-cycle request to send one write transaction.
REQ-007 data_i  input  DATA_W: DAC code to write.
REQ-008 pd_i  input  2: power-down bits PD1:PD0.
REQ-009 sda_i  input  1: SDA line as sampled from the pad.
REQ-010 scl_oe  output  1: 1 pulls SCL low, 0 releases it (open-drain).
REQ-011 sda_oe  output  1: 1 pulls SDA low, 0 releases it (open-drain).
REQ-012 busy  output  1: high from acceptance of a request until the STOP completes.
REQ-013 done  output  1: one-cycle pulse at the end of each transaction.
REQ-014 nack  output  1: sticky flag, set when any ACK slot reads 1; cleared on the next accepted start.

Function
REQ-015 A quarter-tick counter shall count 0..CLK_DIV-1 while busy and issue one tick on wrap; it shall be held at 0 in IDLE.
REQ-016 Start is accepted only when in IDLE; start while busy shall be ignored, with no effect on latched data or the flags.
REQ-017 On acceptance, data_i and pd_i shall be latched and busy shall assert on the next clk edge; later changes to the inputs shall not affect the frame.
REQ-018 FSM states: IDLE, START, BITS, STOP, DONE.
REQ-019 START state, 2 quarters: SDA is released with SCL released, then SDA is pulled low while SCL stays released.
REQ-020 BITS: 27 bit slots, indexed 0..26, of 4 quarters each.
REQ-021 In each bit slot: Q0 SCL low and SDA driven to the bit; Q1 and Q2 SCL released; Q3 SCL low.
REQ-022 SDA shall change only in Q0.
REQ-023 Slot content, MSB first:
- slots 0..7: {DEV_ADDR, 1'b0}
- slot 8: ACK
- slots 9..16: {2'b00, PD1, PD0, D11..D8}
- slot 17: ACK
- slots 18..25: D7..D0
- slot 26: ACK
REQ-024 In ACK slots, SDA shall be released, and sda_i shall be sampled on the tick ending Q1.
REQ-025 STOP state, 3 quarters: SCL low with SDA low, then SCL released, then SDA released.
REQ-026 DONE shall last one clk cycle: done=1, busy deasserts on the same edge, and the FSM returns to IDLE.
REQ-027 A start asserted on the cycle busy falls shall be ignored; a start one cycle later shall be accepted.
REQ-028 The bit counter shall wrap 26 -> exit to STOP, never to 0 within a frame.

Reset
REQ-029 While rst_n=0, all outputs and state shall take these values:
- scl_oe=0 and sda_oe=0 (lines released)
- busy=0, done=0, nack=0
- FSM in IDLE, counters at 0
REQ-030 rst_n asserted mid-frame shall release both lines immediately (asynchronously), with no STOP generated; after reset, the next start begins a fresh frame.

Configuration
REQ-031 Macro I2C_DAC_WRITER_NACK_ABORT_EN.
- Defined: a NACK in any ACK slot sets nack, and the FSM jumps to STOP after that slot's Q3, skipping the remaining slots; done still pulses.
- Undefined: nack is still recorded, but all 27 slots are always sent.

Verification
REQ-032 CLK_DIV=4, DEV_ADDR=7'h60, data_i=12'hA5C, pd_i=0, sda_i tied 0 -> bytes decoded on SCL rising edges are C0, 0A, 5C; nack=0; done pulses once; frame length 2+27*4+3 quarters = 113*4 clk, plus 1 DONE cycle.
REQ-033 Start pulse issued mid-frame with different data -> the frame is unchanged and no second transaction follows.
REQ-034 sda_i driven 1 during slot 8, macro defined -> nack=1; STOP follows slot 8 with no data bytes on the bus; done pulses. Macro undefined -> all 3 bytes are sent and nack=1.
REQ-035 rst_n pulled low during slot 12 -> scl_oe=sda_oe=0 and busy=0 within the same cycle; a new start afterwards produces a complete, correct frame.
REQ-036 DATA_W=8, data_i=8'hFF, pd_i=2'b11 -> second byte 3F, third byte F0.
REQ-037 Protocol checker throughout all scenarios: SDA changes only while SCL is low, except the START and STOP edges.
